// File: rtl/config_cursor_ctrl.sv
// config_cursor_ctrl
//   Edit-side controller for the clock/date/timer display. Debounced button pulses are
//   turned into config_mode, cursor_location and the parpadeo blink. A 6-digit BCD edit
//   buffer is loaded from the live source when an edit mode is entered. It is committed
//   with a one-cycle wr_en strobe when that mode is left through btn_mode.
//
//   Optional feature: define CFG_AUTO_EXIT_EN to cancel an edit after TIMEOUT_CYCLES idle
//   cycles. The block then returns to NORMAL with no commit.
//
// Parameters
//   BLINK_HALF      clk cycles per parpadeo half-period
//   TIMEOUT_CYCLES  idle cycles before auto-exit (CFG_AUTO_EXIT_EN only)
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   btn_mode/left/right/up/down     1-cycle button pulses
//   live_time, live_date, live_timer  24-bit BCD live values, packed {F2, F1, F0}
//   config_mode                     0 normal, 1 hora, 2 fecha, 3 timer
//   cursor_location                 2 left field, 1 middle, 0 right
//   parpadeo                        cursor blink
//   edit_bcd                        edit buffer, same packing as live_*
//   wr_en, wr_target                1-cycle commit strobe and its destination (1..3)
//
// Mode-to-mode hand-over (1->2, 2->3)
//   In the commit cycle, edit_bcd must still show the committed value. The live value
//   sampled on the btn_mode edge is therefore parked in pend_q. It appears on edit_bcd one
//   cycle later. During that parked cycle, all edits and commits act on pend_q.
module config_cursor_ctrl #(
    parameter int unsigned BLINK_HALF     = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [23:0] live_time,
    input  logic [23:0] live_date,
    input  logic [23:0] live_timer,
    output logic [1:0]  config_mode,
    output logic [1:0]  cursor_location,
    output logic        parpadeo,
    output logic [23:0] edit_bcd,
    output logic        wr_en,
    output logic [1:0]  wr_target
);

    typedef enum logic [1:0] {
        StNormal = 2'd0,
        StHora   = 2'd1,
        StFecha  = 2'd2,
        StTimer  = 2'd3
    } mode_e;

    localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    if (BLINK_HALF < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("BLINK_HALF and TIMEOUT_CYCLES must both be at least 1");
    end

    mode_e              mode_q;
    logic [1:0]         cursor_q;
    logic               parp_q;
    logic [23:0]        edit_q;
    logic [23:0]        pend_q;
    logic               load_pend_q;
    logic               wr_en_q;
    logic [1:0]         wr_target_q;
    logic [BlinkW-1:0]  blink_q;

`ifdef CFG_AUTO_EXIT_EN
    localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [IdleW-1:0]   idle_q;
    logic               timeout;
`endif

    // Combinational helpers
    mode_e       next_mode;
    logic [23:0] live_next;
    logic [23:0] cur_buf;
    logic [7:0]  field;
    logic [7:0]  fval;
    logic [7:0]  fmin;
    logic [7:0]  fmax;
    logic        fvalid;
    logic [7:0]  up_bin;
    logic [7:0]  dn_bin;
    logic [7:0]  new_field;
    logic [23:0] edited;
    logic        any_btn;
    logic        move_cursor;
    logic        edit_field;

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [7:0] t;
        logic [7:0] o;
        t = v / 8'd10;
        o = v - t * 8'd10;
        return {t[3:0], o[3:0]};
    endfunction

    always_comb begin
        next_mode = mode_e'(mode_q + 2'd1);
        case (next_mode)
            StHora:  live_next = live_time;
            StFecha: live_next = live_date;
            StTimer: live_next = live_timer;
            default: live_next = 24'h0;
        endcase
    end

    assign cur_buf = load_pend_q ? pend_q : edit_q;

    always_comb begin
        case (cursor_q)
            2'd2:    field = cur_buf[23:16];
            2'd1:    field = cur_buf[15:8];
            default: field = cur_buf[7:0];
        endcase
    end

    // Field limits: hour 0-23 and min/sec 0-59 in time modes; day/month/year in date mode.
    always_comb begin
        fmin = 8'd0;
        fmax = 8'd59;
        if (mode_q == StFecha) begin
            case (cursor_q)
                2'd2: begin
                    fmin = 8'd1;
                    fmax = 8'd31;
                end
                2'd1: begin
                    fmin = 8'd1;
                    fmax = 8'd12;
                end
                default: begin
                    fmin = 8'd0;
                    fmax = 8'd99;
                end
            endcase
        end else if (cursor_q == 2'd2) begin
            fmax = 8'd23;
        end
    end

    always_comb begin
        fval   = {4'd0, field[7:4]} * 8'd10 + {4'd0, field[3:0]};
        fvalid = (field[7:4] <= 4'd9) && (field[3:0] <= 4'd9) && (fval >= fmin) &&
                 (fval <= fmax);
        // Out-of-range values snap to the wrap target of the pressed direction.
        up_bin    = (!fvalid || fval == fmax) ? fmin : fval + 8'd1;
        dn_bin    = (!fvalid || fval == fmin) ? fmax : fval - 8'd1;
        new_field = to_bcd(btn_up ? up_bin : dn_bin);
        edited    = cur_buf;
        case (cursor_q)
            2'd2:    edited[23:16] = new_field;
            2'd1:    edited[15:8]  = new_field;
            default: edited[7:0]   = new_field;
        endcase
    end

    assign any_btn     = btn_mode | btn_left | btn_right | btn_up | btn_down;
    assign move_cursor = btn_left ^ btn_right;
    assign edit_field  = !btn_left && !btn_right && (btn_up ^ btn_down);

`ifdef CFG_AUTO_EXIT_EN
    assign timeout = !any_btn && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= StNormal;
            cursor_q    <= 2'd2;
            parp_q      <= 1'b0;
            edit_q      <= 24'h0;
            pend_q      <= 24'h0;
            load_pend_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_target_q <= 2'd0;
            blink_q     <= '0;
`ifdef CFG_AUTO_EXIT_EN
            idle_q      <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            if (btn_mode) begin
                if (mode_q != StNormal) begin
                    wr_en_q     <= 1'b1;
                    wr_target_q <= mode_q;
                    edit_q      <= cur_buf;
                    pend_q      <= live_next;
                    load_pend_q <= (next_mode != StNormal);
                end else begin
                    edit_q      <= live_next;
                    load_pend_q <= 1'b0;
                end
                mode_q   <= next_mode;
                cursor_q <= 2'd2;
                parp_q   <= (next_mode != StNormal);
                blink_q  <= '0;
`ifdef CFG_AUTO_EXIT_EN
                idle_q   <= '0;
`endif
            end else if (mode_q == StNormal) begin
                parp_q  <= 1'b0;
                blink_q <= '0;
`ifdef CFG_AUTO_EXIT_EN
                idle_q  <= '0;
            end else if (timeout) begin
                // Edit cancelled: buffer holds, nothing is written back.
                mode_q      <= StNormal;
                cursor_q    <= 2'd2;
                parp_q      <= 1'b0;
                blink_q     <= '0;
                idle_q      <= '0;
                edit_q      <= cur_buf;
                load_pend_q <= 1'b0;
`endif
            end else begin
                load_pend_q <= 1'b0;
                edit_q      <= edit_field ? edited : cur_buf;
                if (move_cursor) begin
                    if (btn_left && cursor_q != 2'd2) begin
                        cursor_q <= cursor_q + 2'd1;
                    end else if (btn_right && cursor_q != 2'd0) begin
                        cursor_q <= cursor_q - 2'd1;
                    end
                end
                if (any_btn) begin
                    parp_q  <= 1'b1;
                    blink_q <= '0;
                end else if (blink_q == BlinkW'(BLINK_HALF - 1)) begin
                    parp_q  <= ~parp_q;
                    blink_q <= '0;
                end else begin
                    blink_q <= blink_q + BlinkW'(1);
                end
`ifdef CFG_AUTO_EXIT_EN
                idle_q <= any_btn ? '0 : idle_q + IdleW'(1);
`endif
            end
        end
    end

    assign config_mode     = mode_q;
    assign cursor_location = cursor_q;
    assign parpadeo        = parp_q;
    assign edit_bcd        = edit_q;
    assign wr_en           = wr_en_q;
    assign wr_target       = wr_target_q;

endmodule

// File: tb/tb_config_cursor_ctrl.sv
// Directed bench for config_cursor_ctrl with BLINK_HALF=4, TIMEOUT_CYCLES=16.
// Each step pushes the expected post-edge output vector to a scoreboard queue. The step then
// drives one cycle of buttons and pops and compares the vector 1 ns after the clock edge.
module tb_config_cursor_ctrl;

    typedef struct packed {
        logic [1:0]  mode;
        logic [1:0]  cur;
        logic        par;
        logic [23:0] edit;
        logic        we;
        logic [1:0]  wt;
    } obs_t;

    localparam logic [4:0] BN = 5'b00000;
    localparam logic [4:0] BM = 5'b10000;
    localparam logic [4:0] BL = 5'b01000;
    localparam logic [4:0] BR = 5'b00100;
    localparam logic [4:0] BU = 5'b00010;
    localparam logic [4:0] BD = 5'b00001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [23:0] live_time = 24'h0;
    logic [23:0] live_date = 24'h0;
    logic [23:0] live_timer = 24'h0;
    logic [1:0]  config_mode;
    logic [1:0]  cursor_location;
    logic        parpadeo;
    logic [23:0] edit_bcd;
    logic        wr_en;
    logic [1:0]  wr_target;

    int checks = 0;
    int errors = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    config_cursor_ctrl #(
        .BLINK_HALF(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .live_time(live_time),
        .live_date(live_date),
        .live_timer(live_timer),
        .config_mode(config_mode),
        .cursor_location(cursor_location),
        .parpadeo(parpadeo),
        .edit_bcd(edit_bcd),
        .wr_en(wr_en),
        .wr_target(wr_target)
    );

    always #5 clk = ~clk;

    // Blink level on the i-th idle cycle after a button press (half-period of 4 cycles).
    function automatic logic blink_exp(input int i);
        return (((i + 1) / 4) % 2) == 0;
    endfunction

    task automatic push(input string tag, input logic [1:0] m, input logic [1:0] c,
                        input logic p, input logic [23:0] e, input logic we,
                        input logic [1:0] wt);
        obs_t o;
        o.mode = m;
        o.cur  = c;
        o.par  = p;
        o.edit = e;
        o.we   = we;
        o.wt   = wt;
        exp_q.push_back(o);
        tag_q.push_back(tag);
    endtask

    task automatic tick(input logic [4:0] b);
        obs_t  got;
        obs_t  want;
        string tag;
        {btn_mode, btn_left, btn_right, btn_up, btn_down} = b;
        @(posedge clk);
        #1;
        {btn_mode, btn_left, btn_right, btn_up, btn_down} = BN;
        got = {config_mode, cursor_location, parpadeo, edit_bcd, wr_en, wr_target};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h, required a queued expectation", got);
        end else begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (got === want) else begin
                errors++;
                $error("FAIL %s: observed mode=%0d cur=%0d par=%b edit=%h we=%b wt=%0d, expected mode=%0d cur=%0d par=%b edit=%h we=%b wt=%0d",
                       tag, got.mode, got.cur, got.par, got.edit, got.we, got.wt,
                       want.mode, want.cur, want.par, want.edit, want.we, want.wt);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        reset = 1'b1;
        push("reset", 2'd0, 2'd2, 1'b0, 24'h000000, 1'b0, 2'd0); tick(BN);
        push("reset_hold", 2'd0, 2'd2, 1'b0, 24'h000000, 1'b0, 2'd0); tick(BN);
        reset = 1'b0;
        live_time  = 24'h235958;
        live_date  = 24'h001399;
        live_timer = 24'h123456;

        // Hora mode: load, hour wrap, cursor saturation, second wrap both ways
        push("entry_hora", 2'd1, 2'd2, 1'b1, 24'h235958, 1'b0, 2'd0); tick(BM);
        push("hour_up_wrap", 2'd1, 2'd2, 1'b1, 24'h005958, 1'b0, 2'd0); tick(BU);
        push("right_1", 2'd1, 2'd1, 1'b1, 24'h005958, 1'b0, 2'd0); tick(BR);
        push("right_0", 2'd1, 2'd0, 1'b1, 24'h005958, 1'b0, 2'd0); tick(BR);
        push("right_sat", 2'd1, 2'd0, 1'b1, 24'h005958, 1'b0, 2'd0); tick(BR);
        push("sec_up", 2'd1, 2'd0, 1'b1, 24'h005959, 1'b0, 2'd0); tick(BU);
        push("sec_up_wrap", 2'd1, 2'd0, 1'b1, 24'h005900, 1'b0, 2'd0); tick(BU);
        push("sec_dn_wrap", 2'd1, 2'd0, 1'b1, 24'h005959, 1'b0, 2'd0); tick(BD);
        push("up_down_same", 2'd1, 2'd0, 1'b1, 24'h005959, 1'b0, 2'd0); tick(BU | BD);
        push("left_right_same", 2'd1, 2'd0, 1'b1, 24'h005959, 1'b0, 2'd0); tick(BL | BR);
        for (int i = 0; i < 8; i++) begin
            push("blink_hora", 2'd1, 2'd0, blink_exp(i), 24'h005959, 1'b0, 2'd0); tick(BN);
        end

        // Mode beats up; commit to time, then date value lands one cycle later
        push("commit_hora", 2'd2, 2'd2, 1'b1, 24'h005959, 1'b1, 2'd1); tick(BM | BU);
        push("date_load", 2'd2, 2'd2, 1'b1, 24'h001399, 1'b0, 2'd1); tick(BN);
        push("day_invalid_up", 2'd2, 2'd2, 1'b1, 24'h011399, 1'b0, 2'd1); tick(BU);
        push("to_month", 2'd2, 2'd1, 1'b1, 24'h011399, 1'b0, 2'd1); tick(BR);
        push("month_invalid_dn", 2'd2, 2'd1, 1'b1, 24'h011299, 1'b0, 2'd1); tick(BD);
        for (int i = 0; i < 3; i++) begin
            push("left_sat", 2'd2, 2'd2, 1'b1, 24'h011299, 1'b0, 2'd1); tick(BL);
        end
        push("to_mid", 2'd2, 2'd1, 1'b1, 24'h011299, 1'b0, 2'd1); tick(BR);
        push("to_year", 2'd2, 2'd0, 1'b1, 24'h011299, 1'b0, 2'd1); tick(BR);
        push("year_up_wrap", 2'd2, 2'd0, 1'b1, 24'h011200, 1'b0, 2'd1); tick(BU);
        push("year_dn_wrap", 2'd2, 2'd0, 1'b1, 24'h011299, 1'b0, 2'd1); tick(BD);

`ifdef CFG_AUTO_EXIT_EN
        for (int i = 0; i < 15; i++) begin
            push("idle_before_exit", 2'd2, 2'd0, blink_exp(i), 24'h011299, 1'b0, 2'd1);
            tick(BN);
        end
        push("auto_exit", 2'd0, 2'd2, 1'b0, 24'h011299, 1'b0, 2'd1); tick(BN);
        push("after_auto_exit", 2'd0, 2'd2, 1'b0, 24'h011299, 1'b0, 2'd1); tick(BN);
        push("reenter_hora", 2'd1, 2'd2, 1'b1, 24'h235958, 1'b0, 2'd1); tick(BM);
        push("reenter_fecha", 2'd2, 2'd2, 1'b1, 24'h235958, 1'b1, 2'd1); tick(BM);
        // Commit in the parked cycle writes the date sampled one edge earlier
        push("commit_parked", 2'd3, 2'd2, 1'b1, 24'h001399, 1'b1, 2'd2); tick(BM);
`else
        for (int i = 0; i < 100; i++) begin
            push("fecha_persist", 2'd2, 2'd0, blink_exp(i), 24'h011299, 1'b0, 2'd1); tick(BN);
        end
        push("commit_fecha", 2'd3, 2'd2, 1'b1, 24'h011299, 1'b1, 2'd2); tick(BM);
`endif

        // Timer mode, then exit to NORMAL with commit
        push("timer_load", 2'd3, 2'd2, 1'b1, 24'h123456, 1'b0, 2'd2); tick(BN);
        push("timer_hour_up", 2'd3, 2'd2, 1'b1, 24'h133456, 1'b0, 2'd2); tick(BU);
        push("commit_timer", 2'd0, 2'd2, 1'b0, 24'h133456, 1'b1, 2'd3); tick(BM);
        push("strobe_one_cycle", 2'd0, 2'd2, 1'b0, 24'h133456, 1'b0, 2'd3); tick(BN);
        push("normal_ignores_up", 2'd0, 2'd2, 1'b0, 24'h133456, 1'b0, 2'd3); tick(BU);
        push("normal_ignores_right", 2'd0, 2'd2, 1'b0, 24'h133456, 1'b0, 2'd3); tick(BR);

        // Reset mid-edit discards the buffer and never strobes
        live_time = 24'h105030;
        push("entry_hora2", 2'd1, 2'd2, 1'b1, 24'h105030, 1'b0, 2'd3); tick(BM);
        push("hour_up2", 2'd1, 2'd2, 1'b1, 24'h115030, 1'b0, 2'd3); tick(BU);
        reset = 1'b1;
        push("reset_mid_edit", 2'd0, 2'd2, 1'b0, 24'h000000, 1'b0, 2'd0); tick(BM);
        reset = 1'b0;
        push("after_reset", 2'd0, 2'd2, 1'b0, 24'h000000, 1'b0, 2'd0); tick(BN);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d entries, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
